// File: rtl/commit_trace_if.sv
// Commit-port and debug readout bundle for commit_trace_buffer.
// master = ROB commit side plus debug host; slave = trace buffer.
interface commit_trace_if #(
    parameter int XLEN         = 32,
    parameter int PREG_W       = 6,
    parameter int COMMIT_WIDTH = 2
);
    logic [COMMIT_WIDTH-1:0]        commit_valid;
    logic [COMMIT_WIDTH*XLEN-1:0]   commit_pc;
    logic [COMMIT_WIDTH*32-1:0]     commit_instr;
    logic [COMMIT_WIDTH*5-1:0]      commit_rd_arch;
    logic [COMMIT_WIDTH*PREG_W-1:0] commit_rd_phy;
    logic [COMMIT_WIDTH*XLEN-1:0]   commit_wdata;

    logic                           rd_valid;
    logic                           rd_ready;
    logic [XLEN-1:0]                rd_pc;
    logic [31:0]                    rd_instr;
    logic [4:0]                     rd_rd_arch;
    logic [PREG_W-1:0]              rd_rd_phy;
    logic [XLEN-1:0]                rd_wdata;

    modport master (
        output commit_valid, commit_pc, commit_instr, commit_rd_arch, commit_rd_phy, commit_wdata,
        output rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_rd_arch, rd_rd_phy, rd_wdata
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr, commit_rd_arch, commit_rd_phy, commit_wdata,
        input  rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_rd_arch, rd_rd_phy, rd_wdata
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Circular trace buffer of retired instructions with wrap/stop capture,
// PC trigger with post-trigger freeze, and drop/retire counters.
module commit_trace_buffer #(
    parameter int XLEN         = 32,
    parameter int PREG_W       = 6,
    parameter int COMMIT_WIDTH = 2,
    parameter int DEPTH        = 16,
    parameter int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    commit_trace_if.slave    bus,
    input  logic             mode_stop,
    input  logic             trig_en,
    input  logic [XLEN-1:0]  trig_pc,
    input  logic [CNT_W-1:0] post_count,
    input  logic             arm,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state,
    output logic [31:0]      drop_cnt,
    output logic [63:0]      retire_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {ARMED = 2'd0, TRIGGERED = 2'd1, FROZEN = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d, post_q, post_d;
    logic [31:0]            drop_q, drop_d;
    logic [63:0]            retire_q, retire_d;
    logic                   pop;
    logic [COMMIT_WIDTH-1:0] we;
    logic [PTR_W-1:0]       waddr [COMMIT_WIDTH];

    logic [XLEN-1:0]        mem_pc    [DEPTH];
    logic [31:0]            mem_instr [DEPTH];
    logic [4:0]             mem_arch  [DEPTH];
    logic [PREG_W-1:0]      mem_phy   [DEPTH];
    logic [XLEN-1:0]        mem_wdata [DEPTH];

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    assign bus.rd_valid   = (count_q != '0);
    assign bus.rd_pc      = mem_pc[head_q];
    assign bus.rd_instr   = mem_instr[head_q];
    assign bus.rd_rd_arch = mem_arch[head_q];
    assign bus.rd_rd_phy  = mem_phy[head_q];
    assign bus.rd_wdata   = mem_wdata[head_q];
    assign pop            = bus.rd_valid && bus.rd_ready;

    assign count      = count_q;
    assign state      = state_q;
    assign drop_cnt   = drop_q;
    assign retire_cnt = retire_q;

    // Lanes are walked oldest-first so trigger, post-count and freeze take effect mid-cycle.
    always_comb begin
        int n, avail, drops, ovf, occ, retired;
        state_d = state_q;
        post_d  = post_q;
        we      = '0;
        n       = 0;
        drops   = 0;
        retired = 0;
        avail   = DEPTH - int'(count_q) + int'(pop);
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            waddr[i] = tail_q + PTR_W'(n);
            retired += int'(bus.commit_valid[i]);
            if (bus.commit_valid[i] && state_d != FROZEN) begin
                if (!mode_stop || n < avail) begin
                    we[i] = 1'b1;
                    n++;
                    if (state_d == ARMED) begin
                        if (trig_en && bus.commit_pc[i*XLEN +: XLEN] == trig_pc) begin
                            post_d  = post_count;
                            state_d = (post_count == '0) ? FROZEN : TRIGGERED;
                        end
                    end else begin
                        post_d = post_d - CNT_W'(1);
                        if (post_d == '0) state_d = FROZEN;
                    end
                end else begin
                    drops++;
                end
            end
        end
        // In wrap mode the excess pushes overwrite the oldest records, so head follows.
        ovf = (n > avail) ? n - avail : 0;
        occ = int'(count_q) - int'(pop) + n;
        if (occ > DEPTH) occ = DEPTH;
        head_d   = head_q + PTR_W'(int'(pop) + ovf);
        tail_d   = tail_q + PTR_W'(n);
        count_d  = CNT_W'(occ);
        drop_d   = sat_add32(drop_q, 32'(drops));
        retire_d = retire_q + 64'(retired);
        if (arm) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            drop_d  = '0;
            state_d = ARMED;
            post_d  = post_q;
            we      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARMED;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            post_q   <= '0;
            drop_q   <= '0;
            retire_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            post_q   <= post_d;
            drop_q   <= drop_d;
            retire_q <= retire_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (we[i]) begin
                mem_pc[waddr[i]]    <= bus.commit_pc[i*XLEN +: XLEN];
                mem_instr[waddr[i]] <= bus.commit_instr[i*32 +: 32];
                mem_arch[waddr[i]]  <= bus.commit_rd_arch[i*5 +: 5];
                mem_phy[waddr[i]]   <= bus.commit_rd_phy[i*PREG_W +: PREG_W];
                mem_wdata[waddr[i]] <= bus.commit_wdata[i*XLEN +: XLEN];
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (DEPTH=16, COMMIT_WIDTH=2).
module tb_commit_trace_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_stop = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [4:0]  post_count = '0;
    logic        arm = 1'b0;
    logic [4:0]  count;
    logic [1:0]  state;
    logic [31:0] drop_cnt;
    logic [63:0] retire_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_retire = '0;

    commit_trace_if #(.XLEN(32), .PREG_W(6), .COMMIT_WIDTH(2)) bus ();

    commit_trace_buffer #(
        .XLEN(32), .PREG_W(6), .COMMIT_WIDTH(2), .DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .mode_stop(mode_stop), .trig_en(trig_en), .trig_pc(trig_pc),
        .post_count(post_count), .arm(arm),
        .count(count), .state(state), .drop_cnt(drop_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        bus.commit_valid   = v;
        bus.commit_pc      = {pc1, pc0};
        bus.commit_instr   = {16'hC0DE, pc1[15:0], 16'hC0DE, pc0[15:0]};
        bus.commit_rd_arch = {pc1[6:2], pc0[6:2]};
        bus.commit_rd_phy  = {pc1[7:2], pc0[7:2]};
        bus.commit_wdata   = {~pc1, ~pc0};
    endtask

    // One clock with the given lanes and rd_ready; returns at the following negedge.
    task automatic cyc(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1, input logic rr);
        set_lanes(v, pc0, pc1);
        bus.rd_ready = rr;
        exp_retire += 64'(v[0]) + 64'(v[1]);
        @(negedge clk);
        bus.commit_valid = '0;
        bus.rd_ready     = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    initial begin
        set_lanes(2'b00, '0, '0);
        bus.rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_retire", retire_cnt, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Wrap: 20 records into 16 slots, oldest four overwritten.
        for (int c = 0; c < 10; c++) cyc(2'b11, 32'(8*c), 32'(8*c+4), 1'b0);
        chk("wrap_count", 64'(count), 64'd16);
        chk("wrap_head_pc", 64'(bus.rd_pc), 64'h10);
        chk("wrap_head_instr", 64'(bus.rd_instr), 64'hC0DE0010);
        chk("wrap_head_arch", 64'(bus.rd_rd_arch), 64'd4);
        chk("wrap_head_phy", 64'(bus.rd_rd_phy), 64'd4);
        chk("wrap_head_wdata", 64'(bus.rd_wdata), 64'hFFFFFFEF);
        chk("wrap_drop", 64'(drop_cnt), 64'd0);
        chk("wrap_retire", retire_cnt, 64'd20);
        chk("wrap_rd_valid", 64'(bus.rd_valid), 64'd1);

        // Stop mode: first 16 kept, last 4 dropped, then drain in order.
        mode_stop = 1'b1;
        pulse_arm();
        chk("arm_count", 64'(count), 64'd0);
        chk("arm_retire_kept", retire_cnt, 64'd20);
        for (int c = 0; c < 10; c++) cyc(2'b11, 32'(8*c), 32'(8*c+4), 1'b0);
        chk("stop_count", 64'(count), 64'd16);
        chk("stop_head_pc", 64'(bus.rd_pc), 64'h0);
        chk("stop_drop", 64'(drop_cnt), 64'd4);
        chk("stop_retire", retire_cnt, 64'd40);
        for (int i = 0; i < 16; i++) begin
            chk("stop_pop_pc", 64'(bus.rd_pc), 64'(4*i));
            cyc(2'b00, '0, '0, 1'b1);
        end
        chk("stop_drained_valid", 64'(bus.rd_valid), 64'd0);
        chk("stop_drained_count", 64'(count), 64'd0);

        // Trigger at 0x20 with three post records: freeze after 0x2C.
        mode_stop  = 1'b0;
        trig_en    = 1'b1;
        trig_pc    = 32'h20;
        post_count = 5'd3;
        pulse_arm();
        for (int c = 0; c < 7; c++) begin
            cyc(2'b11, 32'(8*c), 32'(8*c+4), 1'b0);
            chk("trig_state", 64'(state), (c < 4) ? 64'd0 : (c == 4) ? 64'd1 : 64'd2);
        end
        chk("trig_count", 64'(count), 64'd12);
        chk("trig_drop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 12; i++) begin
            chk("trig_pop_pc", 64'(bus.rd_pc), 64'(4*i));
            cyc(2'b00, '0, '0, 1'b1);
        end
        chk("trig_drained_valid", 64'(bus.rd_valid), 64'd0);
        chk("frozen_after_drain", 64'(state), 64'd2);

        // post_count = 0 on lane 0: lane 1 neither captured nor dropped.
        mode_stop  = 1'b1;
        trig_pc    = 32'h100;
        post_count = 5'd0;
        pulse_arm();
        cyc(2'b11, 32'h100, 32'h104, 1'b0);
        chk("post0_state", 64'(state), 64'd2);
        chk("post0_count", 64'(count), 64'd1);
        chk("post0_head_pc", 64'(bus.rd_pc), 64'h100);
        chk("post0_drop", 64'(drop_cnt), 64'd0);
        cyc(2'b11, 32'h108, 32'h10C, 1'b0);
        chk("frozen_count", 64'(count), 64'd1);
        chk("frozen_drop", 64'(drop_cnt), 64'd0);

        // Full in stop mode with simultaneous pop: one lane accepted, one dropped.
        trig_en = 1'b0;
        pulse_arm();
        for (int c = 0; c < 8; c++) cyc(2'b11, 32'(8*c), 32'(8*c+4), 1'b0);
        chk("full_count", 64'(count), 64'd16);
        chk("full_drop", 64'(drop_cnt), 64'd0);
        cyc(2'b11, 32'h200, 32'h204, 1'b1);
        chk("poppush_count", 64'(count), 64'd16);
        chk("poppush_drop", 64'(drop_cnt), 64'd1);
        chk("poppush_head_pc", 64'(bus.rd_pc), 64'h4);
        for (int i = 0; i < 15; i++) cyc(2'b00, '0, '0, 1'b1);
        chk("poppush_tail_pc", 64'(bus.rd_pc), 64'h200);
        chk("poppush_tail_count", 64'(count), 64'd1);

        // Arm while TRIGGERED, with commits in the same cycle ignored.
        mode_stop  = 1'b0;
        trig_en    = 1'b1;
        trig_pc    = 32'h8;
        post_count = 5'd10;
        cyc(2'b11, 32'h0, 32'h4, 1'b0);
        cyc(2'b11, 32'h8, 32'hC, 1'b0);
        chk("pre_arm_state", 64'(state), 64'd1);
        chk("pre_arm_count", 64'(count), 64'd5);
        chk("pre_arm_drop", 64'(drop_cnt), 64'd1);
        set_lanes(2'b11, 32'h8, 32'hC);
        bus.rd_ready = 1'b1;
        arm = 1'b1;
        exp_retire += 64'd2;
        @(negedge clk);
        arm = 1'b0;
        bus.commit_valid = '0;
        bus.rd_ready = 1'b0;
        chk("arm_trig_count", 64'(count), 64'd0);
        chk("arm_trig_state", 64'(state), 64'd0);
        chk("arm_trig_valid", 64'(bus.rd_valid), 64'd0);
        chk("arm_trig_drop", 64'(drop_cnt), 64'd0);
        chk("arm_trig_retire", retire_cnt, exp_retire);

        // Asynchronous reset in the middle of a capture cycle.
        trig_en = 1'b0;
        cyc(2'b11, 32'h40, 32'h44, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd2);
        set_lanes(2'b11, 32'h48, 32'h4C);
        #2 rst = 1'b1;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_valid", 64'(bus.rd_valid), 64'd0);
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_drop", 64'(drop_cnt), 64'd0);
        chk("midrst_retire", retire_cnt, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.commit_valid = '0;
        exp_retire = '0;
        cyc(2'b01, 32'h80, 32'h0, 1'b0);
        chk("postrst_count", 64'(count), 64'd1);
        chk("postrst_pc", 64'(bus.rd_pc), 64'h80);
        chk("postrst_retire", retire_cnt, exp_retire);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Parametrised, synthesizable successor to the simulation-only debug-print helpers: it captures per-lane commit records from the ROB retire stage into a circular trace buffer. It supports wrap or stop-when-full capture, a PC trigger with post-trigger freeze, and drop and retire counters. It sits beside the ROB commit port and exposes a valid/ready readout port for a debug host.

## Interface
- `XLEN`, 32, data/PC width
- `PREG_W`, 6, physical register index width
- `COMMIT_WIDTH`, 2, retire lanes per cycle (1..4)
- `DEPTH`, 16, buffer entries (power of two, at least `COMMIT_WIDTH`)
- `CNT_W`, `$clog2(DEPTH)+1`, occupancy width (derived)

Clock and reset are fixed: one clock, `clk`; reset `rst` is asynchronous and active-high.

- `clk`  in  1  clock
- `rst`  in  1  async active-high reset
- `commit_valid`  in  `COMMIT_WIDTH`  lane retires this cycle (lane 0 oldest)
- `commit_pc`  in  `COMMIT_WIDTH*XLEN`  instruction address per lane
- `commit_instr`  in  `COMMIT_WIDTH*32`  raw instruction word
- `commit_rd_arch`  in  `COMMIT_WIDTH*5`  architectural rd
- `commit_rd_phy`  in  `COMMIT_WIDTH*PREG_W`  new physical rd
- `commit_wdata`  in  `COMMIT_WIDTH*XLEN`  rd writeback value
- `mode_stop`  in  1  0 = wrap (overwrite oldest), 1 = stop when full
- `trig_en`  in  1  enable PC trigger
- `trig_pc`  in  `XLEN`  trigger address
- `post_count`  in  `CNT_W`  records to capture after the trigger record
- `arm`  in  1  pulse: clear buffer and drop counter, state goes to ARMED
- `rd_valid`  out  1  `count != 0`
- `rd_ready`  in  1  host accepts head record
- `rd_pc`, `rd_instr`, `rd_rd_arch`, `rd_rd_phy`, `rd_wdata`  out  per-field widths  head record
- `count`  out  `CNT_W`  occupancy
- `state`  out  2  0 ARMED, 1 TRIGGERED, 2 FROZEN
- `drop_cnt`  out  32  records rejected in stop mode (saturating)
- `retire_cnt`  out  64  total valid commit lanes (wrapping)

## Operation
- Storage is a register array with `head` and `tail` pointers of `$clog2(DEPTH)` bits that wrap modulo `DEPTH`. The `rd_*` outputs read combinationally from `head`.
- Pop occurs when `rd_valid && rd_ready`. The pop is applied before the same cycle's pushes.
- Pushes: valid lanes are written in lane order to consecutive slots starting at `tail`.
- Let `n` = accepted pushes and `avail = DEPTH - count + pop`.
  - Wrap mode: every capturable lane is accepted. `overflow = max(0, n - avail)` advances `head`. `count_next = min(DEPTH, count - pop + n)`.
  - Stop mode: the first `avail` capturable lanes are accepted. The remainder increment `drop_cnt`, which saturates at `2^32-1`.
- Capturable lanes are all valid lanes in ARMED and TRIGGERED. In FROZEN no lanes are capturable, and non-captured lanes are not counted as drops.
- `retire_cnt` increments by popcount(`commit_valid`) every cycle regardless of state. It is cleared only by `rst`.
- State machine:
  - ARMED -> TRIGGERED: `trig_en` is set and the lowest valid lane with `commit_pc == trig_pc` is accepted. The post counter loads `post_count`. Later lanes in the same cycle decrement it.
  - TRIGGERED: each accepted record decrements the post counter. At zero, state goes to FROZEN, and later lanes in that cycle are not captured. With `post_count = 0`, FROZEN is entered right after the trigger record.
  - FROZEN: holds until `arm`. Reads still drain the buffer.
  - `arm` from any state: `head = tail = count = 0`, `drop_cnt = 0`, state ARMED. `arm` has priority over same-cycle pushes and pops, so those are ignored.
  - `trig_en = 0` leaves the block in ARMED, capturing continuously.
  - A trigger-lane record rejected in stop mode does not trigger.

## Timing
- Reset values: all pointers and `count` = 0, `rd_valid` = 0, `state` = ARMED, `drop_cnt` = 0, `retire_cnt` = 0. Storage is not reset.
- Write latency: a record committed in cycle N is visible on `rd_*` in cycle N+1 if it is at the head.
- `rd_valid` never depends combinationally on `rd_ready`.
- Pop plus push in the same cycle at full capacity (stop mode) accepts one lane.
- Asserting `rst` mid-capture returns the block to reset values asynchronously. Capture resumes on the first edge after deassertion.

## Test plan
- Wrap, `DEPTH=16`, `COMMIT_WIDTH=2`, 10 cycles of 2 lanes with PCs 0x0,0x4,...,0x4C, no reads -> `count=16`, head `rd_pc=0x10`, `drop_cnt=0`, `retire_cnt=20`.
- Stop mode, same stimulus -> `count=16`, head `rd_pc=0x0`, `drop_cnt=4`. Then 16 pops yield PCs 0x0..0x3C in order and `rd_valid=0`.
- `trig_pc=0x20`, `post_count=3`, 2 lanes/cycle from PC 0 -> state goes TRIGGERED on the cycle carrying 0x20 and FROZEN once 0x2C is captured. The last record is 0x2C, and 0x30 onward is not captured.
- `post_count=0`, trigger on lane 0 with both lanes valid -> only the trigger record is captured that cycle, state FROZEN, lane 1 not dropped (`drop_cnt` unchanged).
- Full buffer in stop mode with `rd_ready=1` and 2 valid lanes -> one pop, lane 0 accepted, lane 1 dropped, `count` stays 16.
- `rst` asserted mid-stream, and separately `arm` pulsed while TRIGGERED -> outputs return to reset values; after `arm`, `retire_cnt` is preserved.
